// File: rtl/regbus_serial_master.sv
// Byte-stream initiator for the 3-bit-address / 32-bit register bus.
// Command bytes arrive on rx; write acks and read data return on tx.
module regbus_serial_master #(
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  ACK_BYTE   = 8'hA5,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
    input  logic        i_clk,
    input  logic        i_rstb,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [2:0]  o_addr,
    output logic [31:0] o_wdata,
    output logic        o_wr_en,
    input  logic [31:0] i_rdata,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WRITE,
        S_WACK,
        S_RWAIT,
        S_RSEND,
        S_ERR
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rshift_q, rshift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  lat_q, lat_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic rx_fire;
    logic tx_fire;

    assign o_rx_ready = (state_q == S_IDLE) || (state_q == S_WDATA);
    assign rx_fire    = i_rx_valid && o_rx_ready;
    assign tx_fire    = tx_valid_q && i_tx_ready;

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rshift_q   <= '0;
            byte_cnt_q <= '0;
            lat_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rshift_q   <= rshift_d;
            byte_cnt_q <= byte_cnt_d;
            lat_q      <= lat_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rshift_d   = rshift_q;
        byte_cnt_d = byte_cnt_q;
        lat_d      = lat_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (i_rx_data[6:3] != 4'd0) begin
                        state_d    = S_ERR;
                        tx_valid_d = 1'b1;
                        tx_data_d  = ERR_BYTE;
                    end else if (i_rx_data[7]) begin
                        addr_d     = i_rx_data[2:0];
                        byte_cnt_d = '0;
                        state_d    = S_WDATA;
                    end else begin
                        addr_d  = i_rx_data[2:0];
                        lat_d   = LAT_INIT;
                        state_d = S_RWAIT;
                    end
                end
            end
            S_WDATA: begin
                // Shift right so the first (least significant) byte ends in [7:0].
                if (rx_fire) begin
                    wdata_d    = {i_rx_data, wdata_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d    = S_WACK;
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_BYTE;
            end
            S_WACK, S_ERR: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_RWAIT: begin
                // lat_q == 1 means the counter reaches zero on this edge.
                if (lat_q <= 4'd1) begin
                    lat_d      = '0;
                    rshift_d   = i_rdata;
                    tx_valid_d = 1'b1;
                    tx_data_d  = i_rdata[7:0];
                    byte_cnt_d = '0;
                    state_d    = S_RSEND;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_RSEND: begin
                if (tx_fire) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        rshift_d  = {8'd0, rshift_q[31:8]};
                        tx_data_d = rshift_q[15:8];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_wr_en    = (state_q == S_WRITE);
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: doc/regbus_serial_master.md
Name: regbus_serial_master

Overview:
Byte-stream-to-register-bus initiator. It accepts command bytes on a valid/ready receive stream and drives the 3-bit-address, 32-bit register bus used by the peripheral blocks (gpio etc.). It returns write acknowledges and read data on a valid/ready transmit stream. It sits between a UART/debug byte link and the peripheral address decode, so a host can poke and peek peripheral registers.

Parameters:
RD_LATENCY, 1, cycles from o_addr stable to i_rdata sampled; legal range 1..15.
ACK_BYTE, 8'hA5, byte returned after a completed write.
ERR_BYTE, 8'hEE, byte returned for an illegal command byte.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rstb  input  1  asynchronous active-low reset
i_rx_data  input  8  command/data byte in
i_rx_valid  input  1  i_rx_data valid
o_rx_ready  output  1  block accepts byte; transfer when valid&ready at rising edge
o_tx_data  output  8  response byte out
o_tx_valid  output  1  o_tx_data valid
i_tx_ready  input  1  sink accepts byte; transfer when valid&ready at rising edge
o_addr  output  3  register bus address (to peripheral i_addr)
o_wdata  output  32  register bus write data (to peripheral i_din)
o_wr_en  output  1  register bus write strobe, single-cycle
i_rdata  input  32  register bus read data (from peripheral o_dout)
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (i_rstb low, async): state=IDLE. o_addr=0, o_wdata=0, o_wr_en=0, o_tx_valid=0, o_tx_data=0, byte counter=0, latency counter=0. o_rx_ready=1 once reset releases (it is combinational from state: 1 in IDLE and WDATA only).
- Command byte format: bit7 = 1 write / 0 read; bits[6:3] must be 0; bits[2:0] = address.
- IDLE: on accepted byte:
  - legal write: load o_addr, clear byte counter, go WDATA.
  - legal read: load o_addr, load latency counter=RD_LATENCY, go RWAIT.
  - bits[6:3]!=0: o_addr unchanged, go ERR.
- WDATA: accept 4 bytes, LSB first, shifted into o_wdata (byte k -> bits[8k+7:8k]). On the edge accepting byte 3, go WRITE. Gaps in i_rx_valid are allowed; the count holds.
- WRITE: exactly one cycle. o_wr_en=1, o_addr/o_wdata stable. Next state WACK.
- WACK: o_tx_valid=1, o_tx_data=ACK_BYTE until accepted. Then IDLE.
- RWAIT: o_addr held. Counter decrements each cycle. i_rdata is sampled into the shift register on the edge where the counter reaches 0, i.e. RD_LATENCY edges after the command-accept edge. Same edge: go RSEND, o_tx_valid=1, o_tx_data=i_rdata[7:0].
- RSEND: emit 4 bytes, LSB first. Each byte is held stable while o_tx_valid&!i_tx_ready. On the edge accepting byte 3, o_tx_valid=0 and go IDLE.
- ERR: o_tx_valid=1, o_tx_data=ERR_BYTE until accepted, then IDLE. No bus activity.
- o_wr_en is never asserted outside WRITE. Reads cause no strobe; the bus is read-by-address only.
- o_addr and o_wdata retain their last values in IDLE (no return to 0).
- o_rx_ready=0 in RWAIT/RSEND/WRITE/WACK/ERR. Bytes offered then are not consumed; the upstream holds them.
- Back-to-back: a new command may be accepted in the first IDLE cycle after the final tx handshake.
- Reset mid-operation: the transaction is abandoned. No o_wr_en pulse if in WDATA. o_tx_valid drops immediately.

Test Plan:
1. Write: rx 0x81,EF,BE,AD,DE -> exactly one cycle with o_wr_en=1, o_addr=1, o_wdata=0xDEADBEEF; then tx 0xA5.
2. Read, RD_LATENCY=1: i_rdata=0x12345678, rx 0x00 -> i_rdata sampled 1 edge after accept; tx 78,56,34,12; o_wr_en stays 0.
3. Backpressure: read with i_tx_ready toggling randomly -> each byte held stable until handshake, order 78,56,34,12, no drops or duplicates; o_rx_ready=0 throughout.
4. Illegal command: rx 0x48 -> tx 0xEE, o_addr unchanged, no o_wr_en; the following 0x01 read works normally.
5. Reset mid-write: rx 0x82,11,22 then pulse i_rstb low -> all outputs 0, no o_wr_en; next full write 0x82,44,33,22,11 gives o_wdata=0x11223344.
6. RD_LATENCY=3 with a model delaying i_rdata 3 cycles after o_addr change -> correct word returned; a value presented only at latency 2 is not captured.
